// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types for the sequential Booth multiplier: FSM state
//                enum, Booth digit encodings and multiplier-bit recoders.
//                The radix-4 recoder exists only when BOOTH_RADIX4_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth digit applied to the accumulator in one step
    typedef logic [2:0] digit_t;

    localparam digit_t NOP  = 3'd0;
    localparam digit_t ADD  = 3'd1;
    localparam digit_t SUB  = 3'd2;
    localparam digit_t ADD2 = 3'd3;
    localparam digit_t SUB2 = 3'd4;

    // Radix-2 recoding of {Q[0], q(-1)}
    function automatic digit_t recode_r2(input logic [1:0] bits);
        digit_t d;
        case (bits)
            2'b10:   d = SUB;
            2'b01:   d = ADD;
            default: d = NOP;
        endcase
        return d;
    endfunction

`ifdef BOOTH_RADIX4_EN
    // Radix-4 recoding of {Q[1], Q[0], q(-1)} into 0, +/-A, +/-2A
    function automatic digit_t recode_r4(input logic [2:0] bits);
        digit_t d;
        case (bits)
            3'b001, 3'b010: d = ADD;
            3'b011:         d = ADD2;
            3'b100:         d = SUB2;
            3'b101, 3'b110: d = SUB;
            default:        d = NOP;
        endcase
        return d;
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/booth_step_w.sv
`default_nettype none
// ============================================================================
//  Module      : booth_step_w
//  Description : One combinational Booth step: recode the low multiplier bits,
//                add/subtract the multiplicand multiple into the accumulator,
//                then arithmetic-shift {acc, Q, q(-1)} right. Radix-2 by
//                default; radix-4 (two bits per step) with BOOTH_RADIX4_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_step_w
    import booth_pkg::*;
#(
    parameter int WE = 9
) (
    input  logic [WE-1:0] acc_in,
    input  logic [WE-1:0] q_in,
    input  logic          qm1_in,
    input  logic [WE-1:0] mcand,
    output logic [WE-1:0] acc_out,
    output logic [WE-1:0] q_out,
    output logic          qm1_out
);

    // The sum carries guard bits so the shifted result is exact for every
    // operand pair, including the most negative extended multiplicand.
`ifdef BOOTH_RADIX4_EN
    localparam int GW = WE + 2;
`else
    localparam int GW = WE + 1;
`endif

    logic [GW-1:0] mcand_g;
    logic [GW-1:0] acc_g;
    logic [GW-1:0] addend;
    logic [GW-1:0] sum;
    digit_t        digit;

    assign mcand_g = {{(GW-WE){mcand[WE-1]}}, mcand};
    assign acc_g   = {{(GW-WE){acc_in[WE-1]}}, acc_in};

    // Recode the multiplier bits currently at the bottom of Q
    always_comb begin
`ifdef BOOTH_RADIX4_EN
        digit = recode_r4({q_in[1:0], qm1_in});
`else
        digit = recode_r2({q_in[0], qm1_in});
`endif
    end

    // Select the multiplicand multiple for this digit
    always_comb begin
        addend = '0;
        case (digit)
            ADD:     addend = mcand_g;
            SUB:     addend = -mcand_g;
`ifdef BOOTH_RADIX4_EN
            ADD2:    addend = mcand_g << 1;
            SUB2:    addend = -(mcand_g << 1);
`endif
            default: addend = '0;
        endcase
    end

    assign sum = acc_g + addend;

    // Arithmetic right shift of {sum, Q, q(-1)}; the sign lives in the guard bits
    always_comb begin
`ifdef BOOTH_RADIX4_EN
        acc_out = sum[GW-1:2];
        q_out   = {sum[1:0], q_in[WE-1:2]};
        qm1_out = q_in[1];
`else
        acc_out = sum[GW-1:1];
        q_out   = {sum[0], q_in[WE-1:1]};
        qm1_out = q_in[0];
`endif
    end

endmodule
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mul_seq
//  Description : Sequential Booth multiplier, signed or unsigned WIDTH-bit
//                operands, 2*WIDTH-bit product. WIDTH must be even and >= 4.
//                Radix-2 (WIDTH+1 steps) by default; define BOOTH_RADIX4_EN
//                for radix-4 (WIDTH/2+1 steps). Asynchronous active-high rst.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_RADIX4_EN
    localparam int EW    = WIDTH + 2;
    localparam int STEPS = WIDTH / 2 + 1;
`else
    localparam int EW    = WIDTH + 1;
    localparam int STEPS = WIDTH + 1;
`endif
    localparam int            PW   = 2 * WIDTH;
    localparam int            CW   = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t        state;
    state_t        state_nx;
    logic [EW-1:0] acc;
    logic [EW-1:0] q;
    logic          qm1;
    logic [EW-1:0] mcand;
    logic [CW-1:0] count;

    logic [EW-1:0] step_acc;
    logic [EW-1:0] step_q;
    logic          step_qm1;
    logic          accept;
    logic          last_step;
    logic [EW-1:0] mcand_ext;
    logic [EW-1:0] mplier_ext;

    // start is only honoured when no operation is in flight
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = (state == RUN) && (count == LAST);

    // Sign- or zero-extend operands so unsigned values stay positive
    assign mcand_ext  = {{(EW-WIDTH){signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
    assign mplier_ext = {{(EW-WIDTH){signed_mode & multiplier[WIDTH-1]}}, multiplier};

    booth_step_w #(
        .WE (EW)
    ) u_step (
        .acc_in  (acc),
        .q_in    (q),
        .qm1_in  (qm1),
        .mcand   (mcand),
        .acc_out (step_acc),
        .q_out   (step_q),
        .qm1_out (step_qm1)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; DONE chains straight into RUN on a new start
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (count == LAST) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand capture on accepted start, one Booth step per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            mcand <= '0;
            count <= '0;
        end else if (accept) begin
            acc   <= '0;
            q     <= mplier_ext;
            qm1   <= 1'b0;
            mcand <= mcand_ext;
            count <= '0;
        end else if (state == RUN) begin
            acc   <= step_acc;
            q     <= step_q;
            qm1   <= step_qm1;
            count <= count + CW'(1);
        end
    end

    // Product latched from the final step, held until the next result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
        end else if (last_step) begin
            product <= PW'({step_acc, step_q});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mul_seq
//  Description : Self-checking bench for booth_mul_seq at WIDTH=8 and 16.
//                Directed corner cases plus a random sweep against an
//                integer-arithmetic reference. Honours BOOTH_RADIX4_EN for
//                expected latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_seq;

`ifdef BOOTH_RADIX4_EN
    localparam int LAT8  = 6;
    localparam int LAT16 = 10;
`else
    localparam int LAT8  = 10;
    localparam int LAT16 = 18;
`endif

    logic clk = 1'b0;
    logic rst;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int          sel;
    logic        busy_s, done_s;
    logic [31:0] prod_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .start        (start8),
        .signed_mode  (sm8),
        .multiplicand (a8),
        .multiplier   (b8),
        .busy         (busy8),
        .done         (done8),
        .product      (p8)
    );

    booth_mul_seq #(.WIDTH(16)) u_dut16 (
        .clk          (clk),
        .rst          (rst),
        .start        (start16),
        .signed_mode  (sm16),
        .multiplicand (a16),
        .multiplier   (b16),
        .busy         (busy16),
        .done         (done16),
        .product      (p16)
    );

    assign busy_s = (sel == 1) ? busy16 : busy8;
    assign done_s = (sel == 1) ? done16 : done8;
    assign prod_s = (sel == 1) ? p16 : {16'h0, p8};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int width_of();
        return (sel == 1) ? 16 : 8;
    endfunction

    function automatic int lat_of();
        return (sel == 1) ? LAT16 : LAT8;
    endfunction

    // Exact integer product, truncated to 2*w bits
    function automatic logic [31:0] ref_prod(input int w, input bit sm,
                                             input logic [15:0] a, input logic [15:0] b);
        logic [15:0] am, bm;
        longint      sa, sb;
        logic [63:0] pp;
        am = (w == 8) ? {8'h0, a[7:0]} : a;
        bm = (w == 8) ? {8'h0, b[7:0]} : b;
        sa = longint'(am);
        sb = longint'(bm);
        if (sm && am[w-1]) sa = sa - (longint'(1) << w);
        if (sm && bm[w-1]) sb = sb - (longint'(1) << w);
        pp = 64'(sa * sb);
        return (w == 8) ? {16'h0, pp[15:0]} : pp[31:0];
    endfunction

    task automatic drive(input bit st, input bit sm, input logic [15:0] a, input logic [15:0] b);
        if (sel == 1) begin
            start16 = st; sm16 = sm; a16 = a; b16 = b;
            start8  = 1'b0;
        end else begin
            start8  = st; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
            start16 = 1'b0;
        end
    endtask

    // One operation; operands are scrambled after capture, optional ignored
    // start pulse on cycle 'poke' (negative = none)
    task automatic run_op(input string tag, input bit sm, input logic [15:0] a,
                          input logic [15:0] b, input int poke);
        int          n;
        logic [31:0] exp;
        exp = ref_prod(width_of(), sm, a, b);
        @(negedge clk);
        drive(1'b1, sm, a, b);
        @(negedge clk);
        n = 1;
        while (!done_s && n < 40) begin
            if (n == poke) drive(1'b1, 1'b1, 16'd1, 16'd1);
            else           drive(1'b0, ~sm, 16'($urandom), 16'($urandom));
            @(negedge clk);
            n++;
        end
        drive(1'b0, sm, 16'h0, 16'h0);
        check({tag, ".lat"}, 64'(n), 64'(lat_of()));
        check({tag, ".prod"}, 64'(prod_s), 64'(exp));
        @(negedge clk);
        check({tag, ".pulse"}, 64'(done_s), 64'd0);
    endtask

    initial begin
        int          n;
        int          pulses;
        logic [15:0] ra, rb;
        bit          rs;

        sel = 0;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
        rst = 1'b1;
        #1;
        check("reset.busy", 64'(busy8), 64'd0);
        check("reset.done", 64'(done8), 64'd0);
        check("reset.prod", 64'(p8), 64'd0);
        check("reset.prod16", 64'(p16), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed WIDTH=8 corners
        sel = 0;
        run_op("neg128sq", 1'b1, 16'h0080, 16'h0080, -1);
        check("neg128sq.value", 64'(prod_s), 64'h4000);
        run_op("u255sq", 1'b0, 16'h00FF, 16'h00FF, -1);
        check("u255sq.value", 64'(prod_s), 64'hFE01);
        run_op("s255sq", 1'b1, 16'h00FF, 16'h00FF, -1);
        check("s255sq.value", 64'(prod_s), 64'h0001);
        run_op("7xm3", 1'b1, 16'h0007, 16'h00FD, 4);
        check("7xm3.value", 64'(prod_s), 64'hFFEB);

        // Reset in the middle of an operation
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h0009, 16'h0009);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort.busy", 64'(busy_s), 64'd0);
        check("abort.done", 64'(done_s), 64'd0);
        check("abort.prod", 64'(prod_s), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_s) pulses++;
        end
        check("abort.nopulse", 64'(pulses), 64'd0);

        // start held high: DONE chains directly into the next operation
        @(negedge clk);
        drive(1'b1, 1'b0, 16'd10, 16'd11);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'd3, 16'd5);
        n = 1;
        while (!done_s && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b.lat1", 64'(n), 64'(lat_of()));
        check("b2b.prod1", 64'(prod_s), 64'd110);
        @(negedge clk);
        check("b2b.done_drop", 64'(done_s), 64'd0);
        check("b2b.busy", 64'(busy_s), 64'd1);
        drive(1'b0, 1'b1, 16'h00AA, 16'h0055);
        n = 1;
        while (!done_s && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b.lat2", 64'(n), 64'(lat_of()));
        check("b2b.prod2", 64'(prod_s), 64'h000F);
        @(negedge clk);

        // Random sweep, both widths and both modes
        for (int w = 0; w < 2; w++) begin
            sel = w;
            run_op("minneg", 1'b1, (w == 1) ? 16'h8000 : 16'h0080,
                   (w == 1) ? 16'h8000 : 16'h0080, -1);
            for (int i = 0; i < 30; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rs = 1'($urandom_range(0, 1));
                run_op((w == 1) ? "rand16" : "rand8", rs, ra, rb, -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
